// File: rtl/mult36_seq.sv
// 36x36 sequential multiplier: four 18x18 partial products on one shared slave multiplier
// over a level start/done handshake. Optional MULT36_ZERO_SKIP_EN skips zero-half products.
module mult36_seq #(
  parameter int unsigned HALF_W = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*HALF_W-1:0]   A,
  input  logic [2*HALF_W-1:0]   B,
  output logic                  done,
  output logic [4*HALF_W-1:0]   P,
  output logic                  m_start,
  output logic [HALF_W-1:0]     m_a,
  output logic [HALF_W-1:0]     m_b,
  input  logic                  m_done,
  input  logic [2*HALF_W-1:0]   m_p
);

  localparam int unsigned OpW   = 2 * HALF_W;
  localparam int unsigned ProdW = 4 * HALF_W;

  typedef enum logic [2:0] {StIdle, StIssue, StRelease, StDone, StAbort} state_e;

  state_e            state_q, state_d;
  logic [OpW-1:0]    a_q, a_d, b_q, b_d;
  logic [ProdW-1:0]  acc_q, acc_d, p_q, p_d;
  logic [1:0]        idx_q, idx_d;
  logic              done_q, done_d, m_start_q, m_start_d;
  logic [HALF_W-1:0] m_a_q, m_a_d, m_b_q, m_b_d;

  logic [OpW-1:0]    op_a, op_b;
  logic [2:0]        first_idx;
  logic              nxt_found;
  logic [1:0]        nxt_idx;
  logic [ProdW-1:0]  pp_shifted;
  logic              issue;
  int unsigned       shamt;

  function automatic logic [HALF_W-1:0] half_of(input logic [OpW-1:0] op, input logic hi);
    return hi ? op[OpW-1:HALF_W] : op[HALF_W-1:0];
  endfunction

  // idx bit 1 picks the A half, bit 0 the B half; shift is HALF_W per high half.
  always_comb begin
    op_a      = (state_q == StIdle) ? A : a_q;
    op_b      = (state_q == StIdle) ? B : b_q;
    first_idx = (state_q == StIdle) ? 3'd0 : ({1'b0, idx_q} + 3'd1);
`ifdef MULT36_ZERO_SKIP_EN
    nxt_found = 1'b0;
    nxt_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (3'(i) >= first_idx && half_of(op_a, i[1]) != '0 && half_of(op_b, i[0]) != '0) begin
        nxt_found = 1'b1;
        nxt_idx   = 2'(i);
      end
    end
`else
    nxt_found = ~first_idx[2];
    nxt_idx   = first_idx[1:0];
`endif
    shamt      = HALF_W * (32'(idx_q[0]) + 32'(idx_q[1]));
    pp_shifted = ProdW'(m_p) << shamt;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    p_d       = p_q;
    idx_d     = idx_q;
    done_d    = done_q;
    m_start_d = m_start_q;
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;
    issue     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !done_q) begin
          a_d   = A;
          b_d   = B;
          acc_d = '0;
          idx_d = 2'd0;
          if (nxt_found) begin
            issue = 1'b1;
          end else begin
            p_d     = '0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StIssue: begin
        if (!start) begin
          m_start_d = 1'b0;
          state_d   = StAbort;
        end else if (m_done) begin
          acc_d     = acc_q + pp_shifted;
          m_start_d = 1'b0;
          state_d   = StRelease;
        end
      end
      StRelease: begin
        if (!start) begin
          state_d = StAbort;
        end else if (!m_done) begin
          if (nxt_found) begin
            issue = 1'b1;
          end else begin
            p_d     = acc_q;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StAbort: begin
        if (!m_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Operands only move on the edge that raises m_start.
    if (issue) begin
      idx_d     = nxt_idx;
      m_a_d     = half_of(op_a, nxt_idx[1]);
      m_b_d     = half_of(op_b, nxt_idx[0]);
      m_start_d = 1'b1;
      state_d   = StIssue;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      p_q       <= '0;
      idx_q     <= 2'd0;
      done_q    <= 1'b0;
      m_start_q <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      p_q       <= p_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      m_start_q <= m_start_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
    end
  end

  assign done    = done_q;
  assign P       = p_q;
  assign m_start = m_start_q;
  assign m_a     = m_a_q;
  assign m_b     = m_b_q;

endmodule

// File: doc/mult36_seq.md
Name: mult36_seq

Overview:
- Initiator side of the 18x18 start/done multiplier handshake.
- Accepts two 36-bit operands and computes the 72-bit product as four sequential 18x18 partial products on one external 18x18 multiplier, accumulating them in place.
- Sits between the wide-multiply datapath and a single shared 18x18 multiplier instance.
- Presents the same level start/done protocol upstream.

Parameters:
- HALF_W, 18, half-operand width; must equal the slave multiplier operand width. Operands are 2*HALF_W bits, product is 4*HALF_W bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  upstream request level; hold high until done is seen
- A  in  36  operand A, sampled on the accepting edge
- B  in  36  operand B, sampled on the accepting edge
- done  out  1  result valid; held high while start stays high
- P  out  72  product A*B; stable while done=1
- m_start  out  1  request to slave multiplier (registered)
- m_a  out  18  slave operand A (registered, stable while m_start=1)
- m_b  out  18  slave operand B (registered, stable while m_start=1)
- m_done  in  1  slave done level
- m_p  in  36  slave product, valid while m_done=1

Behaviour:
- Reset: rst_n=0 asynchronously clears done, P, m_start, m_a, m_b, accumulator, index and state; state goes to IDLE. Reset mid-operation discards the operation.
- States: IDLE, ISSUE, RELEASE, DONE, ABORT.
- IDLE, start=1 and done=0:
  - latch A/B, clear accumulator, index=0
  - drive m_a=A[17:0], m_b=B[17:0], m_start=1
  - go to ISSUE
- Partial-product order and shifts:
  - idx0 AL*BL, shift 0
  - idx1 AL*BH, shift 18
  - idx2 AH*BL, shift 18
  - idx3 AH*BH, shift 36
- ISSUE: wait for m_done=1. Then add (m_p << shift) into the 72-bit accumulator (no overflow possible), set m_start=0, go to RELEASE.
- RELEASE: wait for m_done=0. This guarantees the slave has cleared busy before the next request.
  - idx<3: increment idx, load the next halves onto m_a/m_b, set m_start=1, go to ISSUE.
  - idx=3: P<=accumulator, done<=1, go to DONE.
- DONE: hold P and done while start=1. When start=0: done<=0 next edge, go to IDLE. P keeps its last value.
- Upstream start falls while in ISSUE/RELEASE (abort):
  - m_start<=0, go to ABORT.
  - ABORT waits for m_done=0, then goes to IDLE.
  - done never asserts; P unchanged.
- Never start a new slave request while m_done=1.
- Latency with a one-cycle slave: done rises 16 edges after the accepting edge (4 edges per partial product).
- start held high after done: no re-trigger. A new operation requires start low for at least one edge.
- m_a/m_b change only in the same edge that m_start rises.

Optional Feature:
- Macro MULT36_ZERO_SKIP_EN.
- Defined: any partial product whose AL/AH or BL/BH half is zero is skipped without a slave handshake. Selection of the next non-skipped index happens in IDLE and RELEASE.
  - All four skipped (A=0 or B=0): P=0, done rises on the edge after acceptance, m_start never asserts.
  - A=2^18, B=5: only idx2 (AH*BL) is issued; latency 4 edges.
- Undefined: all four partial products are always issued; latency is fixed at 16 edges.

Test Plan:
- Reset released, start=1, A=36'h0_0003_0005? no halves: A=3, B=5, one-cycle slave model -> m_start pulses 4 times, P=72'd15, done rises exactly 16 edges after acceptance, held until start=0.
- A=B=36'hF_FFFF_FFFF -> P=72'hFF_FFFF_FFE0_0000_0001; slave operand sequence (3FFFF,3FFFF) x4; accumulator carries across the 18/36 boundaries.
- Slave with 5-cycle done delay and 3-cycle done release, A=36'h1_2345_6789, B=36'h9_8765_4321 -> P equals the exact 72-bit product; m_start never rises while m_done=1; m_a/m_b stable throughout each ISSUE.
- start dropped in the cycle after the second m_start rise -> ABORT; m_start falls; done stays 0; return to IDLE after m_done falls; next op A=7, B=9 gives P=63.
- rst_n pulsed low mid-RELEASE (asynchronous, between edges) -> done, m_start, P go 0 immediately; after release, a fresh op A=2, B=2 gives P=4.
- MULT36_ZERO_SKIP_EN defined: A=0, B=123 -> P=0, done on edge 1, no m_start; A=2^18, B=5 -> single slave request (m_a=1, m_b=5), P=5*2^18.
